mips_cpu_mult_div: RTL and testbench
====================================

// Module: mips_cpu_mult_div
// PURPOSE
//  Multi-cycle HI/LO unit next to mips_cpu_ALU in the EX stage. Executes MULT, MULTU, DIV, DIVU,
//  MTHI and MTLO (R-type, opcode 0) on the same rs/rt register contents the ALU receives.
//  Holds the architectural HI/LO registers. The controller stalls on busy and reads hi/lo for MFHI/MFLO.
// PARAMETERS
//  DATA_WIDTH  32  operand width; HI/LO are DATA_WIDTH each; iterative latency scales with it
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   synchronous, active-high
//  start       in   1   request; sampled only in IDLE
//  funct       in   6   R-type funct: 18 mult, 19 multu, 1A div, 1B divu, 11 mthi, 13 mtlo
//  rs_content  in   32  multiplicand / dividend / MTHI-MTLO source
//  rt_content  in   32  multiplier / divisor
//  busy        out  1   operation in flight; controller must stall MF*/MT*/mult/div
//  done        out  1   one-cycle pulse: hi/lo hold the new result
//  hi          out  32  HI register (MFHI source)
//  lo          out  32  LO register (MFLO source)
// BEHAVIOUR
//  - Reset: hi=0, lo=0, busy=0, done=0, FSM->IDLE. Applies mid-operation; the pending result is discarded.
//  - FSM: IDLE -> RUN (DATA_WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//  - IDLE + start + mult/multu/div/divu:
//    - latch operands at edge E0 (later input changes are ignored); go to RUN.
//    - For signed ops, latch magnitudes and result sign flags.
//  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle on a 64-bit accumulator.
//  - FIX: apply sign correction and write hi/lo at edge E0+DATA_WIDTH+1. State returns to IDLE.
//  - Signals: busy=1 in the cycles after E0 through E0+DATA_WIDTH+1. done=1 for exactly the cycle
//    after that edge, with busy=0. Total latency = DATA_WIDTH+2 cycles (34).
//  - mult/multu: {hi,lo} = 64-bit signed/unsigned product of rs*rt.
//  - div/divu: lo = quotient, hi = remainder. Quotient truncates toward zero;
//    the remainder takes the dividend's sign.
//  - Divide by zero (div or divu): normal latency, hi = rs_content, lo = 32'hFFFFFFFF.
//  - Signed overflow 0x80000000 / -1: lo = 0x80000000, hi = 0.
//  - mthi/mtlo + start in IDLE: hi (resp. lo) <= rs_content at that edge. busy stays 0.
//    done pulses the next cycle. The other register is unchanged.
//  - start while busy: ignored (no queueing).
//  - start with any other funct: ignored; stays IDLE, no done.
//  - start in the done cycle: accepted (FSM already IDLE).
//  - hi/lo hold their value except at the FIX edge, the mthi/mtlo edge, or reset.
// CONFIGURATION
//  MIPS_CPU_FAST_MULT_EN
//  - Defined: mult/multu use a combinational 64-bit product. hi/lo are written at edge E0 and
//    done=1 the next cycle. busy never asserts for mult/multu. Div is unchanged.
//  - Undefined: mult/multu are iterative, DATA_WIDTH+2 cycles, as above.
// TESTING
//  1 multu FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001; busy 33 cycles, done pulse at cycle 34
//    (fast: done at cycle 1, busy=0)
//  2 mult -3*7 -> hi=FFFFFFFF, lo=FFFFFFEB; mult 7*0 -> hi=0, lo=0
//  3 divu 100/7 -> lo=0000000E, hi=00000002
//  4 div -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF; div 7/-2 -> lo=FFFFFFFD, hi=00000001
//  5 div 80000000/FFFFFFFF -> lo=80000000, hi=0; divu 5/0 -> hi=00000005, lo=FFFFFFFF
//  6 Mid-div abuse:
//    - pulse start (mtlo, rs=1234) -> ignored, lo unchanged
//    - at cycle 10, pulse reset -> next cycle busy=0, hi=lo=0, and no done ever follows
//    - then mthi 0000ABCD -> hi=0000ABCD, lo=0, done 1 cycle

Source files
------------

// File: rtl/mips_cpu_mult_div.sv
// mips_cpu_mult_div: HI/LO unit for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Iterative shift-add multiply and restoring divide run over DATA_WIDTH
// cycles on a 2*DATA_WIDTH accumulator, followed by one sign-fix cycle.
// Optional build macro MIPS_CPU_FAST_MULT_EN: mult/multu use a combinational
// product and complete in a single cycle; divide is unaffected.
module mips_cpu_mult_div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] rs_content,
  input  logic [DATA_WIDTH-1:0] rt_content,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*W-1:0]    acc_q, acc_d;
  logic [W-1:0]      opb_q, opb_d;
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              dz_q, dz_d;
  logic [W-1:0]      hi_q, hi_d;
  logic [W-1:0]      lo_q, lo_d;
  logic              done_q, done_d;

  logic              is_signed, a_neg, b_neg;
  logic [W-1:0]      a_mag, b_mag;
  logic [2*W-1:0]    prod_fix;

  function automatic logic [W-1:0] cond_neg_w(input logic [W-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*W-1:0] cond_neg_2w(input logic [2*W-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  // One shift-add step: add multiplicand to the upper half when the LSB is set, then shift right.
  function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] acc, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b} : {(W+1){1'b0}});
    return {sum, acc[W-1:1]};
  endfunction

  // One restoring step: shift left, subtract divisor if it fits, record the quotient bit.
  // With a zero divisor this degenerates to a pure shift, leaving the dividend in the upper half.
  function automatic logic [2*W-1:0] div_step(input logic [2*W-1:0] acc, input logic [W-1:0] b);
    logic [W:0]   rem_ext;
    logic         ge;
    logic [W-1:0] next_hi;
    rem_ext = acc[2*W-1:W-1];
    ge      = (rem_ext >= {1'b0, b});
    next_hi = ge ? (rem_ext[W-1:0] - b) : rem_ext[W-1:0];
    return {next_hi, acc[W-2:0], ge};
  endfunction

`ifdef MIPS_CPU_FAST_MULT_EN
  function automatic logic [2*W-1:0] fast_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sgn);
    logic [2*W-1:0] ax, bx;
    ax = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    bx = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ax * bx;
  endfunction
`endif

  // Next-state, datapath step and result write-back.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    is_signed = (funct == F_MULT) || (funct == F_DIV);
    a_neg     = is_signed & rs_content[W-1];
    b_neg     = is_signed & rt_content[W-1];
    a_mag     = cond_neg_w(rs_content, a_neg);
    b_mag     = cond_neg_w(rt_content, b_neg);
    prod_fix  = cond_neg_2w(acc_q, neg_lo_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (funct)
            F_MULT, F_MULTU: begin
`ifdef MIPS_CPU_FAST_MULT_EN
              {hi_d, lo_d} = fast_prod(rs_content, rt_content, is_signed);
              done_d       = 1'b1;
`else
              state_d  = S_RUN;
              cnt_d    = '0;
              acc_d    = {{W{1'b0}}, a_mag};
              opb_d    = b_mag;
              is_div_d = 1'b0;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = 1'b0;
              dz_d     = 1'b0;
`endif
            end
            F_DIV, F_DIVU: begin
              state_d  = S_RUN;
              cnt_d    = '0;
              acc_d    = {{W{1'b0}}, a_mag};
              opb_d    = b_mag;
              is_div_d = 1'b1;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = a_neg;
              dz_d     = (rt_content == '0);
            end
            F_MTHI: begin
              hi_d   = rs_content;
              done_d = 1'b1;
            end
            F_MTLO: begin
              lo_d   = rs_content;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_step(acc_q, opb_q) : mul_step(acc_q, opb_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = cond_neg_w(acc_q[2*W-1:W], neg_hi_q);
          lo_d = dz_q ? {W{1'b1}} : cond_neg_w(acc_q[W-1:0], neg_lo_q);
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and architectural HI/LO registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand and accumulator datapath; only meaningful while RUN/FIX.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    opb_q    <= opb_d;
    is_div_q <= is_div_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
    dz_q     <= dz_d;
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mips_cpu_mult_div.sv
// Testbench for mips_cpu_mult_div: table of operations plus hand-written
// sequences for busy-time abuse, reset mid-operation and ignored functs.
module tb_mips_cpu_mult_div;
  localparam int W = 32;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [5:0]    funct;
  logic [W-1:0]  rs_content, rt_content;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          busy_cyc;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[17];
  logic [31:0] model_hi, model_lo;

  mips_cpu_mult_div #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .rs_content(rs_content), .rt_content(rt_content),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic int exp_latency(input logic [5:0] f);
    if (f == F_MTHI || f == F_MTLO) return 1;
`ifdef MIPS_CPU_FAST_MULT_EN
    if (f == F_MULT || f == F_MULTU) return 1;
`endif
    return W + 2;
  endfunction

  // Called at a negedge; start is sampled at the next posedge (E0).
  task automatic run_op(input vec_t v, input string name);
    exp_t e;
    int   cyc, bcyc;
    bit   seen;
    e.hi       = v.exp_hi;
    e.lo       = v.exp_lo;
    e.lat      = exp_latency(v.f);
    e.busy_cyc = (e.lat == 1) ? 0 : W + 1;
    funct = v.f; rs_content = v.rs; rt_content = v.rt; start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; rs_content = $urandom; rt_content = $urandom;
    cyc = 0; bcyc = 0; seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
      else if (busy) bcyc++;
    end
    e = sb_q.pop_front();
    if (!seen) begin
      check({name, "_timeout"}, 32'(cyc), 32'(e.lat));
    end else begin
      check({name, "_hi"}, hi, e.hi);
      check({name, "_lo"}, lo, e.lo);
      check({name, "_latency"}, 32'(cyc), 32'(e.lat));
      check({name, "_busy_cycles"}, 32'(bcyc), 32'(e.busy_cyc));
      check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    end
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  initial begin
    int dcnt;
    vecs[0]  = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{F_MULT,  32'h00000007, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[3]  = '{F_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[4]  = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5]  = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7]  = '{F_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[8]  = '{F_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[9]  = '{F_MTHI,  32'h0000ABCD, 32'h00000000, 32'h0000ABCD, 32'hFFFFFFFF};
    vecs[10] = '{F_MTLO,  32'h12345678, 32'h00000000, 32'h0000ABCD, 32'h12345678};
    vecs[11] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[12] = '{F_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[13] = '{F_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[14] = '{F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[15] = '{F_DIVU,  32'h12345678, 32'h00000010, 32'h00000008, 32'h01234567};
    vecs[16] = '{F_MULTU, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800};

    reset = 1'b1; start = 1'b0; funct = '0; rs_content = '0; rt_content = '0;
    model_hi = '0; model_lo = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);

    // Back-to-back: each new start lands in the previous op's done cycle.
    for (int i = 0; i < 17; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // done lasts one cycle only.
    @(negedge clk);
    check("done_width", {31'b0, done}, 32'd0);

    // Unsupported funct: nothing happens.
    funct = 6'h20; rs_content = 32'hDEADBEEF; rt_content = 32'h1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("badfunct_activity", 32'(dcnt), 32'd0);
    check("badfunct_hi", hi, model_hi);
    check("badfunct_lo", lo, model_lo);

    // Mid-divide abuse: ignored mtlo, then reset discards the pending result.
    funct = F_DIVU; rs_content = 32'd100; rt_content = 32'd7; start = 1'b1;
    sb_q.push_back('{32'h2, 32'hE, W + 2, W + 1});
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(negedge clk);
    check("abuse_busy", {31'b0, busy}, 32'd1);
    funct = F_MTLO; rs_content = 32'h1234; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("abuse_mtlo_ignored", lo, model_lo);
    check("abuse_no_done", {31'b0, done}, 32'd0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    sb_q.delete();
    model_hi = '0; model_lo = '0;
    @(negedge clk);
    check("abuse_reset_busy", {31'b0, busy}, 32'd0);
    check("abuse_reset_hi", hi, 32'h0);
    check("abuse_reset_lo", lo, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abuse_no_done_after_reset", 32'(dcnt), 32'd0);
    check("abuse_sb_empty", 32'(sb_q.size()), 32'd0);
    run_op('{F_MTHI, 32'h0000ABCD, 32'h0, 32'h0000ABCD, 32'h00000000}, "post_reset_mthi");
    @(negedge clk);
    check("post_reset_done_width", {31'b0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
